ctrlpipe: RTL and testbench

- Parametrised multi-stage control-signal pipeline register. It replaces the per-stage fixed control registers (IF/ID, ID/EX, EX/MEM style).
- Carries a WIDTH-bit control bundle plus a valid bit through DEPTH back-to-back stages.
- Supports per-stage flush, per-stage stall with automatic bubble insertion, and a saturating counter of valid entries discarded by flush.
- Sits between the decoder and the datapath; each stage output drives that stage's control consumers.

---
 rtl/ctrlpipe.sv | 114 +++++++++++
 tb/tb_ctrlpipe.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ctrlpipe.sv
// ctrlpipe: multi-stage control-bundle pipeline register.
// Each stage carries a WIDTH-bit control word plus a valid bit. Stages can be
// flushed or stalled one at a time. A stalled stage also freezes every earlier
// stage. When a stage advances while the stage in front of it holds, it takes
// a bubble. A saturating counter records how many valid entries flushes
// have killed.
module ctrlpipe #(
  parameter int                WIDTH     = 7,
  parameter int                DEPTH     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}},
  parameter int                CNTW      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     vin,
  input  logic [DEPTH-1:0]         stall,
  input  logic [DEPTH-1:0]         flush,
  input  logic                     clr_cnt,
  output logic [DEPTH*WIDTH-1:0]   dout,
  output logic [DEPTH-1:0]         vout,
  output logic [CNTW-1:0]          drop_cnt
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [CNTW-1:0]  cnt_q;
  logic [CNTW-1:0]  cnt_d;
  logic [DEPTH-1:0] hold;
  logic [3:0]       drops;

  // Saturating add of this cycle's drop count (at most 8) to the counter.
  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a,
                                              input logic [3:0]      b);
    logic [CNTW:0] s;
    s = {1'b0, a} + {{(CNTW-3){1'b0}}, b};
    if (s[CNTW]) sat_add = {CNTW{1'b1}};
    else         sat_add = s[CNTW-1:0];
  endfunction

  // hold[i] is the OR of all stalls at or behind stage i.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc     = acc | stall[i];
      hold[i] = acc;
    end
  end

  // Next stage contents. Priority is flush, then hold, then bubble, then advance.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i]  = data_q[i];
      valid_d[i] = valid_q[i];
    end
    if (flush[0]) begin
      data_d[0]  = RESET_VAL;
      valid_d[0] = 1'b0;
    end else if (!hold[0]) begin
      data_d[0]  = din;
      valid_d[0] = vin;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (flush[i]) begin
        data_d[i]  = RESET_VAL;
        valid_d[i] = 1'b0;
      end else if (hold[i]) begin
        data_d[i]  = data_q[i];
        valid_d[i] = valid_q[i];
      end else if (hold[i-1]) begin
        data_d[i]  = RESET_VAL;
        valid_d[i] = 1'b0;
      end else begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  // Count valid entries being flushed this cycle. A clear wins over counting.
  always_comb begin
    drops = 4'd0;
    for (int i = 0; i < DEPTH; i++) begin
      drops = drops + {3'b000, flush[i] & valid_q[i]};
    end
    if (clr_cnt) cnt_d = '0;
    else         cnt_d = sat_add(cnt_q, drops);
  end

  // Stage and counter registers. Reset forces the idle pipe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_dout
    assign dout[g*WIDTH +: WIDTH] = data_q[g];
  end

  assign vout     = valid_q;
  assign drop_cnt = cnt_q;

endmodule

// File: tb/tb_ctrlpipe.sv
// tb_ctrlpipe: directed checks of ctrlpipe with default parameters. A second
// instance with a 4-bit counter shares the same stimulus so that counter
// saturation can be reached in a few cycles.
module tb_ctrlpipe;

  localparam int WIDTH = 7;
  localparam int DEPTH = 2;

  logic                   clk;
  logic                   rst;
  logic [WIDTH-1:0]       din;
  logic                   vin;
  logic [DEPTH-1:0]       stall;
  logic [DEPTH-1:0]       flush;
  logic                   clr_cnt;
  logic [DEPTH*WIDTH-1:0] dout;
  logic [DEPTH-1:0]       vout;
  logic [15:0]            drop_cnt;
  logic [DEPTH*WIDTH-1:0] dout_s;
  logic [DEPTH-1:0]       vout_s;
  logic [3:0]             drop_cnt_s;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt;
  int exp_sat;

  ctrlpipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(16)) u_dut (
    .clk(clk), .rst(rst), .din(din), .vin(vin), .stall(stall),
    .flush(flush), .clr_cnt(clr_cnt), .dout(dout), .vout(vout),
    .drop_cnt(drop_cnt)
  );

  ctrlpipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(4)) u_sat (
    .clk(clk), .rst(rst), .din(din), .vin(vin), .stall(stall),
    .flush(flush), .clr_cnt(clr_cnt), .dout(dout_s), .vout(vout_s),
    .drop_cnt(drop_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pipe(input string tag, input logic [13:0] e_dout,
                          input logic [1:0] e_vout, input logic [15:0] e_cnt);
    chk_eq({tag, ".dout"}, {18'd0, dout}, {18'd0, e_dout});
    chk_eq({tag, ".vout"}, {30'd0, vout}, {30'd0, e_vout});
    chk_eq({tag, ".cnt"},  {16'd0, drop_cnt}, {16'd0, e_cnt});
  endtask

  // Apply inputs, clock once, then sample 1 time unit after the edge.
  task automatic step(input logic [6:0] d, input logic v, input logic [1:0] st,
                      input logic [1:0] fl, input logic clr);
    din = d; vin = v; stall = st; flush = fl; clr_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; din = '0; vin = 1'b0; stall = '0; flush = '0; clr_cnt = 1'b0;
    #2;
    chk_pipe("rst_async", 14'h0, 2'b00, 16'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_pipe("rst_held", 14'h0, 2'b00, 16'd0);
    rst = 1'b0;

    // Streaming: {stage1, stage0} packed into dout.
    step(7'h01, 1'b1, 2'b00, 2'b00, 1'b0); chk_pipe("s1", 14'h0001, 2'b01, 16'd0);
    step(7'h02, 1'b1, 2'b00, 2'b00, 1'b0); chk_pipe("s2", 14'h0082, 2'b11, 16'd0);
    step(7'h03, 1'b1, 2'b00, 2'b00, 1'b0); chk_pipe("s3", 14'h0103, 2'b11, 16'd0);

    // Front stall: stage0 holds 03, stage1 takes a bubble, din ignored.
    step(7'h55, 1'b1, 2'b01, 2'b00, 1'b0); chk_pipe("stall_a", 14'h0003, 2'b01, 16'd0);
    step(7'h66, 1'b1, 2'b01, 2'b00, 1'b0); chk_pipe("stall_b", 14'h0003, 2'b01, 16'd0);
    step(7'h04, 1'b1, 2'b00, 2'b00, 1'b0); chk_pipe("unstall", 14'h0184, 2'b11, 16'd0);

    // Back stall freezes both stages without a bubble.
    step(7'h05, 1'b1, 2'b10, 2'b00, 1'b0); chk_pipe("bstall", 14'h0184, 2'b11, 16'd0);

    // Invalid entries keep their data.
    step(7'h05, 1'b0, 2'b00, 2'b00, 1'b0); chk_pipe("vin0", 14'h0205, 2'b10, 16'd0);
    step(7'h06, 1'b1, 2'b00, 2'b00, 1'b0); chk_pipe("inv_adv", 14'h0286, 2'b01, 16'd0);
    step(7'h07, 1'b1, 2'b00, 2'b00, 1'b0); chk_pipe("refill", 14'h0307, 2'b11, 16'd0);

    // Flush beats stall on stage0; stage1 still takes the bubble.
    step(7'h08, 1'b1, 2'b01, 2'b01, 1'b0); chk_pipe("fl_prio", 14'h0000, 2'b00, 16'd1);
    step(7'h09, 1'b1, 2'b00, 2'b00, 1'b0); chk_pipe("r1", 14'h0009, 2'b01, 16'd1);
    step(7'h0A, 1'b1, 2'b00, 2'b00, 1'b0); chk_pipe("r2", 14'h048A, 2'b11, 16'd1);
    step(7'h0B, 1'b1, 2'b00, 2'b11, 1'b0); chk_pipe("fl_all", 14'h0000, 2'b00, 16'd3);

    // Flush a later stage while an earlier stage stalls.
    step(7'h0C, 1'b1, 2'b00, 2'b00, 1'b0); chk_pipe("r3", 14'h000C, 2'b01, 16'd3);
    step(7'h0D, 1'b1, 2'b00, 2'b00, 1'b0); chk_pipe("r4", 14'h060D, 2'b11, 16'd3);
    step(7'h0E, 1'b1, 2'b01, 2'b10, 1'b0); chk_pipe("fl_st", 14'h000D, 2'b01, 16'd4);

    // Flushing an invalid stage is not counted.
    step(7'h0F, 1'b1, 2'b00, 2'b10, 1'b0); chk_pipe("fl_inv", 14'h000F, 2'b01, 16'd4);
    chk_eq("sat.cnt4", {28'd0, drop_cnt_s}, 32'd4);

    // Drive the counters up two at a time; the 4-bit one must stop at 15.
    exp_cnt = 4;
    exp_sat = 4;
    for (int k = 0; k < 7; k++) begin
      step(7'h11, 1'b1, 2'b00, 2'b00, 1'b0);
      step(7'h12, 1'b1, 2'b00, 2'b00, 1'b0);
      step(7'h13, 1'b1, 2'b00, 2'b11, 1'b0);
      exp_cnt = exp_cnt + 2;
      exp_sat = (exp_sat + 2 > 15) ? 15 : exp_sat + 2;
      chk_eq($sformatf("cnt_loop%0d", k), {16'd0, drop_cnt}, exp_cnt);
      chk_eq($sformatf("sat_loop%0d", k), {28'd0, drop_cnt_s}, exp_sat);
    end
    chk_eq("cnt18", {16'd0, drop_cnt}, 32'd18);
    chk_eq("sat15", {28'd0, drop_cnt_s}, 32'd15);

    // Clear wins over drops in the same cycle.
    step(7'h14, 1'b1, 2'b00, 2'b00, 1'b0);
    step(7'h15, 1'b1, 2'b00, 2'b00, 1'b0);
    step(7'h16, 1'b1, 2'b00, 2'b11, 1'b1); chk_pipe("clr", 14'h0000, 2'b00, 16'd0);
    chk_eq("sat.clr", {28'd0, drop_cnt_s}, 32'd0);
    step(7'h17, 1'b1, 2'b00, 2'b00, 1'b0); chk_pipe("post_clr", 14'h0017, 2'b01, 16'd0);

    // Async reset while stalled with a nonzero count.
    step(7'h18, 1'b1, 2'b00, 2'b00, 1'b0); chk_pipe("r5", 14'h0B98, 2'b11, 16'd0);
    step(7'h19, 1'b1, 2'b00, 2'b10, 1'b0); chk_pipe("r6", 14'h0019, 2'b01, 16'd1);
    step(7'h1A, 1'b1, 2'b00, 2'b00, 1'b0); chk_pipe("r7", 14'h0C9A, 2'b11, 16'd1);
    step(7'h1B, 1'b1, 2'b01, 2'b00, 1'b0); chk_pipe("r8", 14'h001A, 2'b01, 16'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_pipe("rst_mid", 14'h0000, 2'b00, 16'd0);
    @(posedge clk); #1;
    chk_pipe("rst_mid_hold", 14'h0000, 2'b00, 16'd0);
    rst = 1'b0;
    step(7'h1C, 1'b1, 2'b00, 2'b00, 1'b0); chk_pipe("after_rst", 14'h001C, 2'b01, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
